prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 16: number of program words held; SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 8: bits per program word.
REQ-003 Parameter ADDR_W, default 4: address width; SHALL equal log2(DEPTH).
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 load_start  in  1  one-cycle pulse that begins or restarts a program load.
REQ-007 load_end  in  1  one-cycle pulse that terminates a load early.
REQ-008 din  in  1  serial program bit, MSB of each word first.
REQ-009 din_valid  in  1  din carries a bit this cycle.
REQ-010 din_ready  out  1  loader accepts a bit this cycle.
REQ-011 rd_addr  in  ADDR_W  processor-side fetch address.
REQ-012 rd_data  out  WIDTH  registered fetch data.
REQ-013 run  out  1  program is loaded and the processor may execute.
REQ-014 word_count  out  ADDR_W+1  number of words written during the current load.
REQ-015 parity_err  out  1  sticky parity error flag.

Function
REQ-016 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-017 IDLE: load_start SHALL move the FSM to LOAD and clear bit_cnt, wr_addr, word_count and parity_err.
REQ-018 LOAD: din_ready SHALL be 1; it SHALL be 0 in IDLE and DONE (Moore output).
REQ-019 Each cycle with din_valid and din_ready high SHALL shift din into the shift register LSB-side (MSB arrives first) and increment bit_cnt.
REQ-020 On acceptance of the last bit of a word, the assembled word SHALL be written to mem[wr_addr] on that same edge; wr_addr and word_count SHALL then increment and bit_cnt SHALL clear.
REQ-021 Full: when word_count reaches DEPTH, the FSM SHALL enter DONE on that edge; wr_addr SHALL wrap to 0 and no further bits SHALL be accepted.
REQ-022 load_end in LOAD SHALL move the FSM to DONE and discard any partial word.
REQ-023 If load_end coincides with acceptance of a word's final bit, the word SHALL be written before the FSM enters DONE.
REQ-024 load_start while in LOAD SHALL restart the load: counters clear, already-written memory is kept, and the FSM stays in LOAD. load_start SHALL take priority over load_end and din in the same cycle.
REQ-025 DONE: run SHALL be 1; load_start SHALL return the FSM to LOAD, with run 0 from the next cycle.
REQ-026 The read port SHALL update rd_data with mem[rd_addr] every cycle in every state, with one-cycle latency.
REQ-027 A read and write to the same address in the same cycle SHALL return the old data.
REQ-028 load_end in IDLE or DONE SHALL be ignored.

Reset
REQ-029 Reset SHALL force: FSM to IDLE; run, din_ready and parity_err to 0; word_count, wr_addr, bit_cnt and rd_data to 0.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Reset asserted mid-load SHALL abandon the load, including any partial word, and SHALL override all other inputs.

Configuration
REQ-032 Macro PROG_LOADER_PARITY_EN: when defined, each word SHALL be WIDTH+1 bits long, consisting of the data bits followed by an even-parity bit.
REQ-033 With PROG_LOADER_PARITY_EN, a parity mismatch SHALL suppress the write, leave wr_addr and word_count unchanged, and set parity_err until the next load_start or reset.
REQ-034 Without PROG_LOADER_PARITY_EN, words SHALL be WIDTH bits long and parity_err SHALL be tied to 0.

Structure
REQ-035 Package prog_loader_pkg SHALL hold the FSM state enum and the default WIDTH/DEPTH constants.
REQ-036 The storage array with its registered read port SHALL be the sub-module prog_loader_mem; the FSM, shifter and counters SHALL reside in prog_loader.

Verification
REQ-037 Reset, then load_start, then serial 8'hA5, 8'h3C with din_valid held high -> word_count=2 at cycle 16 after LOAD; rd_addr=0 gives rd_data=8'hA5 and rd_addr=1 gives 8'h3C one cycle later.
REQ-038 Stream 16 words 0x00..0x0F -> DONE and run=1 on the edge after bit 128; din_ready=0 thereafter; the 17th word is ignored.
REQ-039 Send 5 bits, then pulse load_end -> DONE, word_count=0, mem[0] unchanged.
REQ-040 din_valid toggling 1,0,1,0 while sending 8'hFF -> word written only after the 8th accepted bit; word_count=1.
REQ-041 Assert reset after 3 words plus 4 bits -> IDLE, run=0, word_count=0; mem[0..2] still readable.
REQ-042 With PROG_LOADER_PARITY_EN: send 8'h01 with parity bit 0 -> parity_err=1, word_count=0; then send 8'h01 with parity bit 1 -> mem[0]=8'h01 and parity_err stays 1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and default sizing for the serial program loader.
package prog_loader_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/prog_loader_mem.sv
// Program storage: one write port from the loader, one registered read port for fetch.
// Contents are deliberately not reset; only the read register is.
module prog_loader_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  // Sampled before the same-edge write lands, so a colliding read returns old data.
  always_comb rd_data_d = mem_q[rd_addr];

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: deserialises MSB-first words into program memory, then raises run.
// Optional PROG_LOADER_PARITY_EN appends an even-parity bit to every word.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              run,
  output logic [ADDR_W:0]   word_count,
  output logic              parity_err
);

`ifdef PROG_LOADER_PARITY_EN
  localparam int WORD_BITS = WIDTH + 1;
`else
  localparam int WORD_BITS = WIDTH;
`endif
  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam int WC_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
  localparam logic [WC_W-1:0]  LAST_WC  = WC_W'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-2:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [WC_W-1:0]        word_count_q, word_count_d;

  logic                   accept, word_last, word_ok, mem_we;
  logic [WORD_BITS-1:0]   shift_nxt;
  logic [WIDTH-1:0]       word_data;

  assign din_ready = (state_q == ST_LOAD);
  assign run       = (state_q == ST_DONE);

  // load_start outranks any bit presented in the same cycle.
  assign accept    = din_valid && din_ready && !load_start;
  assign word_last = accept && (bit_cnt_q == LAST_BIT);
  assign shift_nxt = {shift_q, din};
  assign word_data = shift_nxt[WORD_BITS-1 -: WIDTH];
`ifdef PROG_LOADER_PARITY_EN
  assign word_ok   = ~^shift_nxt;
`else
  assign word_ok   = 1'b1;
`endif
  assign mem_we    = word_last && word_ok;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_LOAD: begin
        if (load_start) begin
          // Restart keeps memory; only the load bookkeeping is cleared.
          state_d      = ST_LOAD;
          bit_cnt_d    = '0;
          wr_addr_d    = '0;
          word_count_d = '0;
        end else if (state_q == ST_LOAD) begin
          if (accept) begin
            shift_d   = shift_nxt[WORD_BITS-2:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (word_last) bit_cnt_d = '0;
          if (mem_we) begin
            wr_addr_d    = wr_addr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
            if (word_count_q == LAST_WC) state_d = ST_DONE;
          end
          if (load_end) begin
            state_d   = ST_DONE;
            bit_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      wr_addr_q    <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;

`ifdef PROG_LOADER_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = parity_err_q;
    if (load_start)                 parity_err_d = 1'b0;
    else if (word_last && !word_ok) parity_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  prog_loader_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (mem_we),
    .wr_addr (wr_addr_q),
    .wr_data (word_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Scenario-driven bench for prog_loader; expected fetch data queued as words are sent.
module tb_prog_loader;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset, load_start, load_end, din, din_valid;
  logic              din_ready, run, parity_err;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    string             name;
  } rd_exp_t;
  rd_exp_t sb[$];

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_end   (load_end),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .run        (run),
    .word_count (word_count),
    .parity_err (parity_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din_valid = 1'b1;
    din       = b;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
`ifdef PROG_LOADER_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic push_exp(input int a, input logic [WIDTH-1:0] d, input string n);
    rd_exp_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; load_end = 1'b0;
    din = 1'b0; din_valid = 1'b0; rd_addr = '0;
    tick(); tick();
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run got=%b exp=0", run); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", din_ready); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL reset_wc got=%0d exp=0", word_count); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd got=%h exp=00", rd_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_two_words();
    rd_exp_t e;
    pulse_start();
    checks++; if (din_ready !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL load_state ready=%b run=%b exp ready=1 run=0", din_ready, run); end
    send_word(8'hA5);
    send_word(8'h3C);
    checks++; if (word_count !== 5'd2) begin errors++; $display("FAIL two_words_wc got=%0d exp=2", word_count); end
    push_exp(0, 8'hA5, "two_words_m0");
    push_exp(1, 8'h3C, "two_words_m1");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd_addr = e.addr; tick(); checks++;
      if (rd_data !== e.data) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.data); end
    end
  endtask

  task automatic test_back_to_back();
    rd_exp_t e;
    pulse_start();
    send_word(8'hAA);
    // restart with a bit presented in the same cycle: the bit must be dropped
    load_start = 1'b1; din_valid = 1'b1; din = 1'b1;
    tick();
    load_start = 1'b0; din_valid = 1'b0;
    checks++; if (word_count !== 5'd0 || din_ready !== 1'b1) begin errors++; $display("FAIL restart wc=%0d ready=%b exp wc=0 ready=1", word_count, din_ready); end
    send_word(8'h55);
    checks++; if (word_count !== 5'd1) begin errors++; $display("FAIL restart_wc got=%0d exp=1", word_count); end
    push_exp(0, 8'h55, "restart_m0");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd_addr = e.addr; tick(); checks++;
      if (rd_data !== e.data) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.data); end
    end
  endtask

  task automatic test_full();
    rd_exp_t e;
    logic [WIDTH-1:0] last_w;
    pulse_start();
    for (int w = 0; w < DEPTH - 1; w++) send_word(WIDTH'(w));
    last_w = WIDTH'(DEPTH - 1);
    for (int i = WIDTH - 1; i >= 1; i--) send_bit(last_w[i]);
`ifdef PROG_LOADER_PARITY_EN
    send_bit(last_w[0]);
    checks++; if (run !== 1'b0 || word_count !== 5'd15) begin errors++; $display("FAIL full_pre run=%b wc=%0d exp run=0 wc=15", run, word_count); end
    send_bit(^last_w);
`else
    checks++; if (run !== 1'b0 || word_count !== 5'd15) begin errors++; $display("FAIL full_pre run=%b wc=%0d exp run=0 wc=15", run, word_count); end
    send_bit(last_w[0]);
`endif
    checks++; if (run !== 1'b1 || din_ready !== 1'b0) begin errors++; $display("FAIL full_done run=%b ready=%b exp run=1 ready=0", run, din_ready); end
    checks++; if (word_count !== 5'd16) begin errors++; $display("FAIL full_wc got=%0d exp=16", word_count); end
    send_word(8'hFF);
    checks++; if (word_count !== 5'd16 || run !== 1'b1) begin errors++; $display("FAIL full_extra wc=%0d run=%b exp wc=16 run=1", word_count, run); end
    for (int w = 0; w < DEPTH; w++) push_exp(w, WIDTH'(w), "full_mem");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd_addr = e.addr; tick(); checks++;
      if (rd_data !== e.data) begin errors++; $display("FAIL %s[%0d] got=%h exp=%h", e.name, e.addr, rd_data, e.data); end
    end
  endtask

  task automatic test_load_end();
    rd_exp_t e;
    pulse_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    load_end = 1'b1; tick(); load_end = 1'b0;
    checks++; if (run !== 1'b1 || din_ready !== 1'b0) begin errors++; $display("FAIL end_done run=%b ready=%b exp run=1 ready=0", run, din_ready); end
    checks++; if (word_count !== 5'd0) begin errors++; $display("FAIL end_wc got=%0d exp=0", word_count); end
    load_end = 1'b1; tick(); load_end = 1'b0;
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL end_in_done run=%b exp=1", run); end
    push_exp(0, 8'h00, "end_m0");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd_addr = e.addr; tick(); checks++;
      if (rd_data !== e.data) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.data); end
    end
  endtask

  task automatic test_valid_toggle();
    rd_exp_t e;
    pulse_start();
    for (int i = 0; i < WIDTH; i++) begin
      din_valid = 1'b1; din = 1'b1; tick();
      din_valid = 1'b0; din = 1'b0; tick();
      if (i == WIDTH - 2) begin
        checks++; if (word_count !== 5'd0) begin errors++; $display("FAIL toggle_early got=%0d exp=0", word_count); end
      end
    end
`ifdef PROG_LOADER_PARITY_EN
    din_valid = 1'b1; din = 1'b0; tick(); din_valid = 1'b0;
`endif
    checks++; if (word_count !== 5'd1) begin errors++; $display("FAIL toggle_wc got=%0d exp=1", word_count); end
    push_exp(0, 8'hFF, "toggle_m0");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd_addr = e.addr; tick(); checks++;
      if (rd_data !== e.data) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.data); end
    end
  endtask

  task automatic test_reset_midload();
    rd_exp_t e;
    pulse_start();
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1; din_valid = 1'b1; load_start = 1'b1;
    tick();
    reset = 1'b0; din_valid = 1'b0; load_start = 1'b0;
    checks++; if (run !== 1'b0 || din_ready !== 1'b0) begin errors++; $display("FAIL midreset run=%b ready=%b exp 0 0", run, din_ready); end
    checks++; if (word_count !== 5'd0 || rd_data !== '0) begin errors++; $display("FAIL midreset wc=%0d rd=%h exp wc=0 rd=00", word_count, rd_data); end
    load_end = 1'b1; tick(); load_end = 1'b0;
    checks++; if (run !== 1'b0 || din_ready !== 1'b0) begin errors++; $display("FAIL end_in_idle run=%b ready=%b exp 0 0", run, din_ready); end
    push_exp(0, 8'h11, "midreset_m0");
    push_exp(1, 8'h22, "midreset_m1");
    push_exp(2, 8'h33, "midreset_m2");
    push_exp(3, 8'h03, "midreset_m3");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd_addr = e.addr; tick(); checks++;
      if (rd_data !== e.data) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.data); end
    end
  endtask

`ifdef PROG_LOADER_PARITY_EN
  task automatic test_parity();
    rd_exp_t e;
    pulse_start();
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(i == 0);
    send_bit(1'b0);
    checks++; if (parity_err !== 1'b1 || word_count !== 5'd0) begin errors++; $display("FAIL parity_bad perr=%b wc=%0d exp perr=1 wc=0", parity_err, word_count); end
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(i == 0);
    send_bit(1'b1);
    checks++; if (parity_err !== 1'b1 || word_count !== 5'd1) begin errors++; $display("FAIL parity_good perr=%b wc=%0d exp perr=1 wc=1", parity_err, word_count); end
    push_exp(0, 8'h01, "parity_m0");
    while (sb.size() > 0) begin
      e = sb.pop_front(); rd_addr = e.addr; tick(); checks++;
      if (rd_data !== e.data) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, rd_data, e.data); end
    end
    pulse_start();
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clear got=%b exp=0", parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_back_to_back();
    test_full();
    test_load_end();
    test_valid_toggle();
    test_reset_midload();
`ifdef PROG_LOADER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
